val2_shift_sequencer: RTL and testbench

Multi-cycle sequencer for register-specified shifts of the second ALU operand (shift amount taken from Rs[7:0]). These are the cases the single-cycle immediate-amount Val2 path does not cover. The EXE stage hands it Rm, the shift type, the 8-bit amount and the current C flag. The block iterates the shift STEP bits per cycle and returns the 32-bit Val2 and the shifter carry-out over a valid/ready handshake. While a request is in flight it drives `busy`, which the hazard unit uses to stall the pipeline.

---
 rtl/val2_shift_sequencer_if.sv | 27 ++
 rtl/val2_shift_sequencer.sv | 136 +++++++++++++
 tb/tb_val2_shift_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/val2_shift_sequencer_if.sv
// Request/response bundle between the EXE stage and the multi-cycle Val2 shift sequencer.
interface val2_shift_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] op_a;
  logic [1:0]        shift_type;
  logic [7:0]        shift_amt;
  logic              carry_in;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] result;
  logic              carry_out;
  logic              busy;

  modport master (
    output flush, req_valid, op_a, shift_type, shift_amt, carry_in, resp_ready,
    input  req_ready, resp_valid, result, carry_out, busy
  );

  modport slave (
    input  flush, req_valid, op_a, shift_type, shift_amt, carry_in, resp_ready,
    output req_ready, resp_valid, result, carry_out, busy
  );
endinterface

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle register-amount shifter for ALU operand 2, STEP bits per cycle.
// Define VAL2_SEQ_CARRY_EN to build the shifter carry-out path; otherwise carry_out is tied 0.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// SHIFT | iterating the shift; rem==0 means finished, move to DONE
// DONE  | result and carry held until consumer takes them
module val2_shift_sequencer #(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input logic                   clk,
  input logic                   rst,
  val2_shift_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [5:0] STEP_C  = 6'(STEP);
  localparam logic [5:0] WIDTH_C = 6'(DATA_W);
  localparam logic [7:0] MAX_AMT = 8'(DATA_W + 1);

  state_t            state;
  logic [DATA_W-1:0] work;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ror_res;
  logic [DATA_W:0]   lsl_ext;
  logic [DATA_W:0]   lsr_ext;
  logic [DATA_W:0]   asr_ext;
  logic [1:0]        typ;
  logic [5:0]        rem;
  logic [5:0]        eff;
  logic [5:0]        s;
  logic [4:0]        ror_m1;
  logic              sh_c;

`ifdef VAL2_SEQ_CARRY_EN
  logic carry_q;
`else
  logic unused_carry;
  assign unused_carry = sh_c ^ bus.carry_in;
`endif

  assign ror_m1 = bus.shift_amt[4:0] - 5'd1;

  always_comb begin
    eff = 6'd0;
    if (bus.shift_type == 2'b11) begin
      if (bus.shift_amt != 8'd0) eff = {1'b0, ror_m1} + 6'd1;
    end else if (bus.shift_amt > MAX_AMT) begin
      eff = MAX_AMT[5:0];
    end else begin
      eff = bus.shift_amt[5:0];
    end
  end

  assign s = (rem < STEP_C) ? rem : STEP_C;

  // One guard bit on each extended vector captures the last bit shifted out.
  always_comb begin
    lsl_ext = {1'b0, work} << s;
    lsr_ext = {work, 1'b0} >> s;
    asr_ext = $signed({work, 1'b0}) >>> s;
    ror_res = (work >> s) | (work << (WIDTH_C - s));
    shifted = lsl_ext[DATA_W-1:0];
    sh_c    = lsl_ext[DATA_W];
    case (typ)
      2'b01: begin
        shifted = lsr_ext[DATA_W:1];
        sh_c    = lsr_ext[0];
      end
      2'b10: begin
        shifted = asr_ext[DATA_W:1];
        sh_c    = asr_ext[0];
      end
      2'b11: begin
        shifted = ror_res;
        sh_c    = ror_res[DATA_W-1];
      end
      default: ;
    endcase
  end

  // Zero-count requests still pass one cycle through SHIFT so latency is uniform.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      work  <= '0;
      typ   <= '0;
      rem   <= '0;
`ifdef VAL2_SEQ_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            work  <= bus.op_a;
            typ   <= bus.shift_type;
            rem   <= eff;
            state <= SHIFT;
`ifdef VAL2_SEQ_CARRY_EN
            carry_q <= bus.carry_in;
`endif
          end
        end
        SHIFT: begin
          if (rem == 6'd0) begin
            state <= DONE;
          end else begin
            work <= shifted;
            rem  <= rem - s;
`ifdef VAL2_SEQ_CARRY_EN
            carry_q <= sh_c;
`endif
          end
        end
        DONE: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.busy       = (state == SHIFT) || (state == DONE);
  assign bus.result     = work;
`ifdef VAL2_SEQ_CARRY_EN
  assign bus.carry_out  = carry_q;
`else
  assign bus.carry_out  = 1'b0;
`endif
endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Bench for val2_shift_sequencer: directed vector table, corner sequences, random vs reference model.
module tb_val2_shift_sequencer;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef VAL2_SEQ_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  val2_shift_sequencer_if #(.DATA_W(32)) bus ();

  val2_shift_sequencer #(.DATA_W(32), .STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] op;
    logic [1:0]  typ;
    logic [7:0]  amt;
    logic        cin;
    logic [31:0] res;
    logic        c;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: one-shot shift by the effective amount, straight from the shift rules.
  function automatic void model(input logic [31:0] op, input logic [1:0] t, input logic [7:0] amt,
                                input logic cin, output logic [31:0] res, output logic c,
                                output int lat);
    int n;
    logic [63:0] w;
    if (t == 2'b11) n = (amt == 0) ? 0 : ((int'(amt) - 1) % 32) + 1;
    else            n = (amt > 33) ? 33 : int'(amt);
    lat = (n + 3) / 4 + 1;
    res = op;
    c   = cin;
    if (n != 0) begin
      case (t)
        2'b00: begin
          if (n >= 33) begin res = 0; c = 0; end
          else begin w = {32'b0, op} << n; res = w[31:0]; c = w[32]; end
        end
        2'b01: begin
          if (n >= 33) begin res = 0; c = 0; end
          else begin res = op >> n; c = op[n-1]; end
        end
        2'b10: begin
          if (n >= 32) begin res = {32{op[31]}}; c = op[31]; end
          else begin res = $signed(op) >>> n; c = op[n-1]; end
        end
        default: begin
          res = (op >> n) | (op << (32 - n));
          c   = res[31];
        end
      endcase
    end
  endfunction

  task automatic run_txn(input string nm, input logic [31:0] op, input logic [1:0] t,
                         input logic [7:0] amt, input logic cin, input logic [31:0] er,
                         input logic ec, input int elat, input int hold);
    int   cyc;
    logic bad;
    check({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.op_a       = op;
    bus.shift_type = t;
    bus.shift_amt  = amt;
    bus.carry_in   = cin;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.op_a       = $urandom;
    bus.shift_amt  = 8'($urandom);
    bus.carry_in   = ~cin;
    check({nm, " busy/ready after accept"}, {30'b0, bus.busy, bus.req_ready}, 32'b10);
    cyc = 0;
    while (!bus.resp_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " latency"}, 32'(cyc), 32'(elat));
    check({nm, " result"}, bus.result, er);
    check({nm, " carry"}, 32'(bus.carry_out), 32'(ec & CARRY_EN));
    bad = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (bus.result !== er || bus.carry_out !== (ec & CARRY_EN) ||
          bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) check({nm, " held under backpressure"}, 32'(bad), 32'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({nm, " back to idle"}, {29'b0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);
  endtask

  initial begin
    logic        seen;
    logic [31:0] op, er;
    logic [1:0]  t;
    logic [7:0]  a;
    logic        ci, ec;
    int          lat;

    vecs[0]  = '{32'h0000_0001, 2'b00, 8'd4,   1'b0, 32'h0000_0010, 1'b0, 2};
    vecs[1]  = '{32'h8000_0001, 2'b01, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 9};
    vecs[2]  = '{32'h8000_0001, 2'b01, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 10};
    vecs[3]  = '{32'h8000_0000, 2'b10, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 10};
    vecs[4]  = '{32'h0000_00F1, 2'b11, 8'd36,  1'b1, 32'h1000_000F, 1'b0, 2};
    vecs[5]  = '{32'h8000_0000, 2'b11, 8'd32,  1'b0, 32'h8000_0000, 1'b1, 9};
    vecs[6]  = '{32'h1234_5678, 2'b00, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 1};
    vecs[7]  = '{32'h1234_5678, 2'b11, 8'd0,   1'b0, 32'h1234_5678, 1'b0, 1};
    vecs[8]  = '{32'h8000_0001, 2'b00, 8'd1,   1'b0, 32'h0000_0002, 1'b1, 2};
    vecs[9]  = '{32'hFFFF_FFFF, 2'b00, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 9};
    vecs[10] = '{32'h8000_0010, 2'b10, 8'd5,   1'b0, 32'hFC00_0000, 1'b1, 3};
    vecs[11] = '{32'h0000_00F0, 2'b01, 8'd5,   1'b0, 32'h0000_0007, 1'b1, 3};

    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.op_a       = '0;
    bus.shift_type = '0;
    bus.shift_amt  = '0;
    bus.carry_in   = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset flags", {29'b0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);
    check("reset result", bus.result, 32'h0);
    check("reset carry", 32'(bus.carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].typ, vecs[i].amt, vecs[i].cin,
              vecs[i].res, vecs[i].c, vecs[i].lat, (i == 0) ? 5 : 0);

    // Flush mid-SHIFT: abort, no response afterwards.
    bus.op_a = 32'h8000_0000; bus.shift_type = 2'b10; bus.shift_amt = 8'd200;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush mid-shift idle", {29'b0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen = 1'b1;
    end
    check("flush no response", 32'(seen), 32'd0);

    // Flush in DONE discards the pending response.
    bus.op_a = 32'h5; bus.shift_type = 2'b00; bus.shift_amt = 8'd0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-flush done", 32'(bus.resp_valid), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush in done", {29'b0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);

    // req_valid is ignored while flush is asserted.
    bus.req_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    check("flush beats request", {29'b0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);

    // Async reset mid-SHIFT: outputs return to reset values without a clock edge.
    bus.op_a = 32'hFFFF_FFFF; bus.shift_type = 2'b01; bus.shift_amt = 8'd33; bus.carry_in = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset flags", {29'b0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);
    check("async reset result", bus.result, 32'h0);
    check("async reset carry", 32'(bus.carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_txn("post-reset", 32'h0000_0003, 2'b00, 8'd31, 1'b0, 32'h8000_0000, 1'b1, 9, 0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom;
      t  = 2'($urandom_range(0, 3));
      ci = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom_range(0, 8));
        1:       a = 8'($urandom_range(28, 40));
        2:       a = 8'($urandom_range(0, 255));
        default: a = 8'($urandom_range(1, 20));
      endcase
      model(op, t, a, ci, er, ec, lat);
      run_txn($sformatf("rand%0d t%0d a%0d", i, t, a), op, t, a, ci, er, ec, lat,
              $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
